// File: rtl/add_operand_streamer_pkg.sv
// Shared definitions for the add-layer operand streamer: FSM state encoding and RAM address width.
package add_operand_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DECD = 3'd1,
        ST_CAPA = 3'd2,
        ST_SNDA = 3'd3,
        ST_SNDB = 3'd4
    } state_t;

    // RAM holds a full H*W map, so the address covers both dimensions.
    function automatic int unsigned ram_addr_width(input int unsigned height_width);
        return 2 * height_width;
    endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry valid/ready FIFO; DO is the head register and stays put until popped.
module stream_skid2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DI,
    input  logic             PUSH,
    input  logic             POP,
    output logic [WIDTH-1:0] DO,
    output logic             VLD,
    output logic [1:0]       COUNT
);

    logic [WIDTH-1:0] tail;

    // Callers never pop an empty buffer nor push a full one without popping.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            DO    <= '0;
            tail  <= '0;
            COUNT <= 2'd0;
            VLD   <= 1'b0;
        end else begin
            unique case ({PUSH, POP})
                2'b10: begin
                    if (COUNT == 2'd0) DO <= DI;
                    else               tail <= DI;
                    COUNT <= COUNT + 2'd1;
                    VLD   <= 1'b1;
                end
                2'b01: begin
                    DO    <= tail;
                    COUNT <= COUNT - 2'd1;
                    VLD   <= (COUNT != 2'd1);
                end
                2'b11: begin
                    if (COUNT == 2'd2) begin
                        DO   <= tail;
                        tail <= DI;
                    end else begin
                        DO <= DI;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/add_operand_streamer.sv
// Captures skip-branch map A into RAM, then streams A from RAM followed by main-branch map B to the add layer.
module add_operand_streamer
    import add_operand_streamer_pkg::*;
#(
    parameter int unsigned INWIDTH      = 16,
    parameter int unsigned HEIGHT_WIDTH = 5
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    EN,
    input  logic [HEIGHT_WIDTH-1:0] H,
    input  logic [HEIGHT_WIDTH-1:0] W,
    input  logic                    START,
    input  logic [INWIDTH-1:0]      DINA,
    input  logic                    DINA_VLD,
    output logic                    DINA_RDY,
    input  logic [INWIDTH-1:0]      DINB,
    input  logic                    DINB_VLD,
    output logic                    DINB_RDY,
    output logic [INWIDTH-1:0]      DOUT,
    output logic                    DOUT_VLD,
    input  logic                    DOUT_RDY,
    output logic                    BUSY,
    output logic                    DONE
);

    localparam int unsigned AW    = ram_addr_width(HEIGHT_WIDTH);
    localparam int unsigned DEPTH = 1 << AW;

    state_t                  state, next_state;
    logic [HEIGHT_WIDTH-1:0] h_q, w_q;
    logic [AW-1:0]           size_q, prod, cnt, rd_addr;
    logic                    rd_pending;
    logic [INWIDTH-1:0]      ram_q;
    logic [INWIDTH-1:0]      mem [DEPTH];
    logic [1:0]              fifo_count;
    logic [2:0]              fifo_count_next;
    logic                    a_xfer, b_xfer, pop, fifo_push, rd_room, rd_issue;
    logic                    dina_rdy_d, dinb_rdy_d, busy_d, done_d;

    assign a_xfer    = DINA_VLD & DINA_RDY & EN;
    assign b_xfer    = DINB_VLD & DINB_RDY & EN;
    assign pop       = DOUT_VLD & DOUT_RDY & EN;
    assign fifo_push = (rd_pending & EN) | b_xfer;
    assign prod      = AW'(h_q) * AW'(w_q);

    // A read may issue if its data has room on landing, crediting a pop happening now.
    assign rd_room  = ({1'b0, fifo_count} + {2'b0, rd_pending}) < (3'd2 + {2'b0, pop});
    assign rd_issue = EN && (state == ST_SNDA) && (rd_addr < size_q) && rd_room;
    assign fifo_count_next = {1'b0, fifo_count} + {2'b0, fifo_push} - {2'b0, pop};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)   state <= ST_IDLE;
        else if (EN) state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (START) next_state = ST_DECD;
            ST_DECD: next_state = (prod == '0) ? ST_IDLE : ST_CAPA;
            ST_CAPA: if (a_xfer && (cnt == size_q - AW'(1))) next_state = ST_SNDA;
            ST_SNDA: if (rd_issue && (rd_addr == size_q - AW'(1))) next_state = ST_SNDB;
            ST_SNDB: if ((cnt == size_q) && (fifo_count == 2'd0)) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // B is accepted only when no RAM word lands in the same cycle, keeping A ahead of B.
    always_comb begin
        dina_rdy_d = 1'b0;
        dinb_rdy_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        dina_rdy_d = (next_state == ST_CAPA);
        dinb_rdy_d = (next_state == ST_SNDB) && !rd_issue && (fifo_count_next < 3'd2)
                     && ((cnt + AW'(b_xfer)) < size_q);
        busy_d     = (next_state != ST_IDLE);
        done_d     = ((state == ST_DECD) && (prod == '0))
                     || ((state == ST_SNDB) && (next_state == ST_IDLE));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            DINA_RDY <= 1'b0;
            DINB_RDY <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else if (EN) begin
            DINA_RDY <= dina_rdy_d;
            DINB_RDY <= dinb_rdy_d;
            BUSY     <= busy_d;
            DONE     <= done_d;
        end
    end

    // Job parameters, write/B counter and read pointer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            h_q        <= '0;
            w_q        <= '0;
            size_q     <= '0;
            cnt        <= '0;
            rd_addr    <= '0;
            rd_pending <= 1'b0;
        end else if (EN) begin
            rd_pending <= rd_issue;
            if (state == ST_IDLE) begin
                cnt     <= '0;
                rd_addr <= '0;
                if (START) begin
                    h_q <= H;
                    w_q <= W;
                end
            end
            if (state == ST_DECD) size_q <= prod;
            if (a_xfer) cnt <= (cnt == size_q - AW'(1)) ? '0 : cnt + AW'(1);
            if (b_xfer) cnt <= cnt + AW'(1);
            if (rd_issue) rd_addr <= rd_addr + AW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (a_xfer) mem[cnt] <= DINA;
    end

    always_ff @(posedge CLK) begin
        if (rd_issue) ram_q <= mem[rd_addr];
    end

    stream_skid2 #(.WIDTH(INWIDTH)) u_skid (
        .CLK   (CLK),
        .RESET (RESET),
        .DI    (rd_pending ? ram_q : DINB),
        .PUSH  (fifo_push),
        .POP   (pop),
        .DO    (DOUT),
        .VLD   (DOUT_VLD),
        .COUNT (fifo_count)
    );

endmodule
